// File: rtl/p_mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes,
// controller state codes and the datapath select encodings.
package p_mips_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_OREXEC = 4'd10,
        S_ORWB   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J)  || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/p_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the
// cycle on which the access has waited its full budget.
module p_mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic srst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    // A ready on the final cycle still wins, so timeout requires !ready.
    assign timeout = active && !ready && (cnt_reg == LAST_WAIT);

    // Restart from zero whenever the access ends (done, aborted or idle).
    always_ff @(posedge clk) begin
        if (srst || !active || ready || timeout) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/p_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback and drives datapath controls.
module p_multicycle_control
    import p_mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       P_clk,
    input  logic       P_reset,
    input  logic [5:0] P_opcode,
    input  logic       P_mem_ready,
    input  logic       P_Zero,
    output logic       P_PCWrite,
    output logic       P_PCWriteCond,
    output logic       P_IorD,
    output logic       P_MemRead,
    output logic       P_MemWrite,
    output logic       P_IRWrite,
    output logic       P_MemtoReg,
    output logic       P_RegDst,
    output logic       P_RegWrite,
    output logic       P_ALUSrcA,
    output logic [1:0] P_ALUSrcB,
    output logic [1:0] P_ALUOp,
    output logic [1:0] P_PCSource,
    output logic [3:0] P_state,
    output logic       P_illegal,
    output logic       P_bus_error
);

    state_t state_reg;
    state_t state_next;
    logic   wait_active;
    logic   timeout;

    // The zero flag is combined with PCWriteCond inside the datapath.
    logic unused_zero;
    assign unused_zero = P_Zero;

    assign wait_active = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                         (state_reg == S_MEMWR);
    assign P_state     = state_reg;

    p_mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (P_clk),
        .srst    (P_reset),
        .active  (wait_active),
        .ready   (P_mem_ready),
        .timeout (timeout)
    );

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = P_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (P_opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_REXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ORI:       state_next = S_OREXEC;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (P_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = P_mem_ready ? S_MEMWB :
                                   (timeout ? S_FETCH : S_MEMRD);
            S_MEMWR:  state_next = (P_mem_ready || timeout) ? S_FETCH : S_MEMWR;
            S_REXEC:  state_next = S_RWB;
            S_OREXEC: state_next = S_ORWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge P_clk) begin
        if (P_reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Moore decode of controls; fetch writes wait for the memory, and
    // reset forces every control low.
    always_comb begin
        P_PCWrite     = 1'b0;
        P_PCWriteCond = 1'b0;
        P_IorD        = 1'b0;
        P_MemRead     = 1'b0;
        P_MemWrite    = 1'b0;
        P_IRWrite     = 1'b0;
        P_MemtoReg    = 1'b0;
        P_RegDst      = 1'b0;
        P_RegWrite    = 1'b0;
        P_ALUSrcA     = 1'b0;
        P_ALUSrcB     = SRCB_REG;
        P_ALUOp       = ALUOP_ADD;
        P_PCSource    = PCSRC_ALU;
        P_illegal     = 1'b0;
        P_bus_error   = timeout;
        case (state_reg)
            S_FETCH: begin
                P_MemRead = 1'b1;
                P_ALUSrcB = SRCB_FOUR;
                P_IRWrite = P_mem_ready;
                P_PCWrite = P_mem_ready;
            end
            S_DECODE: begin
                P_ALUSrcB = SRCB_IMM_SH;
                P_illegal = !is_known_op(P_opcode);
            end
            S_MEMADR: begin
                P_ALUSrcA = 1'b1;
                P_ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                P_MemRead = 1'b1;
                P_IorD    = 1'b1;
            end
            S_MEMWB: begin
                P_RegWrite = 1'b1;
                P_MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                P_MemWrite = 1'b1;
                P_IorD     = 1'b1;
            end
            S_REXEC: begin
                P_ALUSrcA = 1'b1;
                P_ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                P_RegWrite = 1'b1;
                P_RegDst   = 1'b1;
            end
            S_BRANCH: begin
                P_ALUSrcA     = 1'b1;
                P_ALUOp       = ALUOP_SUB;
                P_PCWriteCond = 1'b1;
                P_PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                P_PCWrite  = 1'b1;
                P_PCSource = PCSRC_JUMP;
            end
            S_OREXEC: begin
                P_ALUSrcA = 1'b1;
                P_ALUSrcB = SRCB_IMM;
                P_ALUOp   = ALUOP_OR;
            end
            S_ORWB: begin
                P_RegWrite = 1'b1;
            end
            default: begin
                P_bus_error = 1'b0;
            end
        endcase
        if (P_reset) begin
            P_PCWrite     = 1'b0;
            P_PCWriteCond = 1'b0;
            P_IorD        = 1'b0;
            P_MemRead     = 1'b0;
            P_MemWrite    = 1'b0;
            P_IRWrite     = 1'b0;
            P_MemtoReg    = 1'b0;
            P_RegDst      = 1'b0;
            P_RegWrite    = 1'b0;
            P_ALUSrcA     = 1'b0;
            P_ALUSrcB     = 2'b00;
            P_ALUOp       = 2'b00;
            P_PCSource    = 2'b00;
            P_illegal     = 1'b0;
            P_bus_error   = 1'b0;
        end
    end

endmodule

// File: tb/tb_p_multicycle_control.sv
// Self-checking bench for p_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_p_multicycle_control;

    localparam logic [5:0] T_R   = 6'b000000;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100;
    localparam logic [5:0] T_J   = 6'b000010;
    localparam logic [5:0] T_ORI = 6'b001101;
    localparam int         MEM_BUDGET = 16;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       ill, be;
    } out_t;

    typedef struct packed {
        logic rdy;
        out_t o;
    } step_t;

    logic       clk = 1'b0;
    logic       P_reset = 1'b1;
    logic [5:0] P_opcode = '0;
    logic       P_mem_ready = 1'b0;
    logic       P_Zero = 1'b0;
    logic       P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite;
    logic       P_IRWrite, P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA;
    logic [1:0] P_ALUSrcB, P_ALUOp, P_PCSource;
    logic [3:0] P_state;
    logic       P_illegal, P_bus_error;

    out_t  obs;
    step_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    p_multicycle_control #(.TIMEOUT(16), .CNT_W(5)) dut (
        .P_clk(clk), .P_reset(P_reset), .P_opcode(P_opcode),
        .P_mem_ready(P_mem_ready), .P_Zero(P_Zero),
        .P_PCWrite(P_PCWrite), .P_PCWriteCond(P_PCWriteCond), .P_IorD(P_IorD),
        .P_MemRead(P_MemRead), .P_MemWrite(P_MemWrite), .P_IRWrite(P_IRWrite),
        .P_MemtoReg(P_MemtoReg), .P_RegDst(P_RegDst), .P_RegWrite(P_RegWrite),
        .P_ALUSrcA(P_ALUSrcA), .P_ALUSrcB(P_ALUSrcB), .P_ALUOp(P_ALUOp),
        .P_PCSource(P_PCSource), .P_state(P_state), .P_illegal(P_illegal),
        .P_bus_error(P_bus_error)
    );

    assign obs = {P_state, P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite,
                  P_IRWrite, P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA,
                  P_ALUSrcB, P_ALUOp, P_PCSource, P_illegal, P_bus_error};

    function automatic out_t blank(input logic [3:0] st);
        out_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit known(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
               op == T_J || op == T_ORI;
    endfunction

    task automatic push(input logic rdy, input out_t o);
        step_t s;
        s.rdy = rdy;
        s.o   = o;
        q.push_back(s);
    endtask

    // Instruction-level model: fw = not-ready fetch cycles, mw = not-ready
    // data cycles (>= budget means the access times out), fto = whole
    // first fetch attempt times out before a clean refetch.
    task automatic build(input logic [5:0] op, input int fw, input int mw, input bit fto);
        out_t o;
        logic [3:0] mst;
        if (fto) begin
            for (int i = 0; i < MEM_BUDGET; i++) begin
                o = blank(4'd0); o.mr = 1; o.asb = 2'b01; o.be = (i == MEM_BUDGET - 1);
                push(1'b0, o);
            end
        end
        for (int i = 0; i < fw; i++) begin
            o = blank(4'd0); o.mr = 1; o.asb = 2'b01;
            push(1'b0, o);
        end
        o = blank(4'd0); o.mr = 1; o.asb = 2'b01; o.pcw = 1; o.irw = 1;
        push(1'b1, o);
        o = blank(4'd1); o.asb = 2'b11; o.ill = !known(op);
        push(1'($urandom), o);
        if (op == T_LW || op == T_SW) begin
            mst = (op == T_LW) ? 4'd3 : 4'd5;
            o = blank(4'd2); o.asa = 1; o.asb = 2'b10;
            push(1'($urandom), o);
            for (int i = 0; i < mw && i < MEM_BUDGET; i++) begin
                o = blank(mst); o.iord = 1; o.mr = (op == T_LW); o.mw = (op == T_SW);
                o.be = (i == MEM_BUDGET - 1);
                push(1'b0, o);
            end
            if (mw < MEM_BUDGET) begin
                o = blank(mst); o.iord = 1; o.mr = (op == T_LW); o.mw = (op == T_SW);
                push(1'b1, o);
                if (op == T_LW) begin
                    o = blank(4'd4); o.rw = 1; o.m2r = 1;
                    push(1'($urandom), o);
                end
            end
        end else if (op == T_R) begin
            o = blank(4'd6); o.asa = 1; o.aop = 2'b10;
            push(1'($urandom), o);
            o = blank(4'd7); o.rw = 1; o.rd = 1;
            push(1'($urandom), o);
        end else if (op == T_BEQ) begin
            o = blank(4'd8); o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01;
            push(1'($urandom), o);
        end else if (op == T_J) begin
            o = blank(4'd9); o.pcw = 1; o.pcs = 2'b10;
            push(1'($urandom), o);
        end else if (op == T_ORI) begin
            o = blank(4'd10); o.asa = 1; o.asb = 2'b10; o.aop = 2'b11;
            push(1'($urandom), o);
            o = blank(4'd11); o.rw = 1;
            push(1'($urandom), o);
        end
    endtask

    // Drives the queued trace one cycle per step and compares every output.
    // Entered and left just after a rising edge.
    task automatic play(input logic [5:0] op, input int zero, input string name);
        P_opcode = op;
        for (int i = 0; i < q.size(); i++) begin
            P_mem_ready = q[i].rdy;
            P_Zero = (zero < 0) ? 1'($urandom) : 1'(zero);
            @(negedge clk);
            n_tests++;
            if (obs !== q[i].o) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, obs, q[i].o);
            end
            @(posedge clk); #1;
        end
        $display("[TB] %s op=%b cycles=%0d", name, op, q.size());
        q.delete();
    endtask

    task automatic test_reset();
        P_reset = 1; P_mem_ready = 1; P_opcode = T_LW;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if (obs !== out_t'(0)) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %h expected %h", i, obs, out_t'(0));
            end
        end
        @(posedge clk); #1;
        P_reset = 0;
        $display("[TB] reset checked");
    endtask

    task automatic test_instructions();
        build(T_LW, 0, 0, 0);  play(T_LW, -1, "lw_zero_wait");
        build(T_R, 3, 0, 0);   play(T_R, -1, "r_fetch_wait3");
        build(T_BEQ, 0, 0, 0); play(T_BEQ, 1, "beq_zero1");
        build(T_BEQ, 0, 0, 0); play(T_BEQ, 0, "beq_zero0");
        build(T_ORI, 0, 0, 0); play(T_ORI, -1, "ori");
        build(T_J, 0, 0, 0);   play(T_J, -1, "jump");
        build(T_SW, 0, 0, 0);  play(T_SW, -1, "sw_zero_wait");
        build(6'b111111, 0, 0, 0); play(6'b111111, -1, "illegal");
    endtask

    task automatic test_timeouts();
        build(T_SW, 0, MEM_BUDGET, 0);      play(T_SW, -1, "sw_timeout");
        build(T_LW, 15, 15, 0);             play(T_LW, -1, "ready_on_last_cycle");
        build(T_R, 0, 0, 1);                play(T_R, -1, "fetch_timeout");
    endtask

    task automatic test_reset_mid_memrd();
        build(T_LW, 0, 10, 0);
        q.pop_back(); q.pop_back();
        play(T_LW, -1, "lw_into_memrd");
        P_reset = 1; P_mem_ready = 1;
        @(negedge clk);
        n_tests++;
        if (obs[17:0] !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_mid_memrd_ctrl: got %h expected 0", obs[17:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (obs !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_memrd_state: got %h expected %h", obs, out_t'(0));
        end
        @(posedge clk); #1;
        P_reset = 0;
        $display("[TB] reset mid-MEMRD checked");
        // Counter must restart from zero after reset: a full fetch timeout.
        build(T_ORI, 0, 0, 1); play(T_ORI, -1, "fetch_timeout_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ORI};
        logic [5:0] op;
        int fw, mw;
        out_t o;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (known(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            fw = $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? MEM_BUDGET : $urandom_range(0, 3);
            build(op, fw, mw, $urandom_range(0, 15) == 0);
            play(op, -1, "random");
        end
        P_mem_ready = 0;
        @(negedge clk);
        o = blank(4'd0); o.mr = 1; o.asb = 2'b01;
        n_tests++;
        if (obs !== o) begin
            n_fail++;
            $display("FAIL final_fetch: got %h expected %h", obs, o);
        end
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_timeouts();
        test_reset_mid_memrd();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
